// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access stage with an inferred single-port RAM,
// programmable wait states and a busy/done handshake to the control unit.
module mem_access_unit #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           memory_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  req_read,
  input  logic                  req_write,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  busy,
  output logic                  done,
  output logic                  addr_error
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [15:0]           addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] read_data_q;
  logic                  wr_q;
  logic                  done_q;
  logic                  addr_error_q;
  logic                  in_range;
  logic                  fire;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // range check uses all 16 address bits before the low bits index the RAM
  assign in_range   = {1'b0, addr_q} < 17'(DEPTH);
  assign fire       = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign busy       = state_q != IDLE;
  assign done       = done_q;
  assign read_data  = read_data_q;
  assign addr_error = addr_error_q;
  // rst gates the write so an aborted access never reaches the array
  always_ff @(posedge clk)
    if (!rst && fire && wr_q && in_range) mem[addr_q[AW-1:0]] <= data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      done_q       <= 1'b0;
      read_data_q  <= '0;
      addr_error_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (req_write || req_read) begin
          state_q <= ACCESS;
          cnt_q   <= 4'(WAIT_CYCLES);
          addr_q  <= memory_address;
          data_q  <= write_data;
          wr_q    <= req_write;
        end
        ACCESS: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        else begin
          state_q      <= DONE;
          done_q       <= 1'b1;
          addr_error_q <= !in_range;
          if (!wr_q) read_data_q <= in_range ? mem[addr_q[AW-1:0]] : '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random accesses checked against a word-array model.
module tb_mem_access_unit;
  localparam int W = 2;
  localparam int DEPTH = 4096;
  logic        clk = 0;
  logic        rst = 1;
  logic [15:0] memory_address = 0;
  logic [15:0] write_data = 0;
  logic        req_read = 0;
  logic        req_write = 0;
  logic [15:0] read_data;
  logic        busy;
  logic        done;
  logic        addr_error;
  logic [15:0] addr0 = 0;
  logic [15:0] wd0 = 0;
  logic        rd0 = 0;
  logic        wr0 = 0;
  logic [15:0] rdata0;
  logic        busy0;
  logic        done0;
  logic        err0;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] mm [int];
  logic [15:0] addrs [$];
  logic [15:0] exp_rd = 0;
  logic        exp_err = 0;

  mem_access_unit #(.DATA_WIDTH(16), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .memory_address(memory_address), .write_data(write_data),
    .req_read(req_read), .req_write(req_write), .read_data(read_data),
    .busy(busy), .done(done), .addr_error(addr_error));

  mem_access_unit #(.DATA_WIDTH(16), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .memory_address(addr0), .write_data(wd0),
    .req_read(rd0), .req_write(wr0), .read_data(rdata0),
    .busy(busy0), .done(done0), .addr_error(err0));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic op(input logic wr, input logic rd, input logic [15:0] a, input logic [15:0] d);
    int k;
    int nb;
    bit seen;
    @(negedge clk);
    req_write = wr; req_read = rd; memory_address = a; write_data = d;
    @(posedge clk); #1;
    req_write = 0; req_read = 0;
    memory_address = 16'($urandom); write_data = 16'($urandom);
    k = 0; nb = 0; seen = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (busy) nb++;
      seen = done;
    end
    if (wr) begin
      if (a < DEPTH) mm[int'(a)] = d;
    end else exp_rd = (a < DEPTH && mm.exists(int'(a))) ? mm[int'(a)] : 16'h0;
    exp_err = a >= DEPTH;
    chk("latency", k, W + 2);
    chk("busy_len", nb, W + 2);
    chk("read_data", read_data, exp_rd);
    chk("addr_error", addr_error, exp_err);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    int nd;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_err", addr_error, 0);

    op(1, 0, 16'h0010, 16'hBEEF);
    op(0, 1, 16'h0010, 16'h0);
    op(1, 1, 16'h0005, 16'h1234);
    op(0, 1, 16'h0005, 16'h0);
    op(1, 0, 16'h0000, 16'h0F0F);
    op(1, 0, 16'h1000, 16'hAAAA);
    op(0, 1, 16'h0000, 16'h0);
    op(0, 1, 16'hFFFF, 16'h0);
    op(1, 0, 16'h0020, 16'h2222);
    op(1, 0, 16'h0030, 16'h3333);
    addrs = '{16'h0010, 16'h0005, 16'h0000, 16'h0020, 16'h0030};

    // extra read pulses while busy and an address change after accept
    @(negedge clk);
    req_read = 1; memory_address = 16'h0010;
    @(posedge clk); #1;
    memory_address = 16'h0020; req_read = 0;
    nd = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done) nd++;
      req_read = (k <= W + 1) ? k[0] : 1'b0;
    end
    chk("pulse_done_count", nd, 1);
    chk("pulse_rdata", read_data, mm[16'h0010]);
    chk("pulse_err", addr_error, 0);
    exp_rd = mm[16'h0010];

    // reset while a write is waiting in ACCESS
    @(negedge clk);
    req_write = 1; memory_address = 16'h0030; write_data = 16'h5555;
    @(posedge clk); #1;
    req_write = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rdata", read_data, 0);
    chk("abort_err", addr_error, 0);
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    exp_rd = 0; exp_err = 0;
    op(0, 1, 16'h0030, 16'h0);

    for (int i = 0; i < 24; i++) begin
      int r;
      logic [15:0] a;
      r = $urandom_range(0, 3);
      case (r)
        0: begin
          a = 16'($urandom_range(0, DEPTH - 1));
          op(1, 1'($urandom_range(0, 1)), a, 16'($urandom));
          addrs.push_back(a);
        end
        1: op(1, 1'($urandom_range(0, 1)), 16'($urandom_range(DEPTH, 65535)), 16'($urandom));
        2: op(0, 1, addrs[$urandom_range(0, addrs.size() - 1)], 16'h0);
        default: op(0, 1, 16'($urandom_range(DEPTH, 65535)), 16'h0);
      endcase
    end

    // zero-wait build: write, then reads with req_read held high
    @(negedge clk);
    wr0 = 1; addr0 = 16'h0007; wd0 = 16'h7777;
    @(posedge clk); #1;
    wr0 = 0; rd0 = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("w0_done", done0, (k % 3) == 2);
      chk("w0_busy", busy0, (k % 3) != 0);
      if (k == 5) chk("w0_rdata", rdata0, 16'h7777);
    end
    rd0 = 0;
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
